alu_share_ctrl: RTL and testbench

//  Sequencer/arbiter sharing one 32-bit ripple ALU (thirty_two_alu) between two requesters.

---
 rtl/alu_share_ctrl_pkg.sv | 48 ++++
 rtl/alu_share_ctrl_rr_arb2.sv | 22 ++
 rtl/alu_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// ============================================================================
// Module  : alu_share_ctrl_pkg
// Brief   : Opcodes, FSM states and opcode-to-select decode for alu_share_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_share_ctrl_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_SLT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic legal;
    logic op1;
    logic op2;
    logic sub;
    logic cin;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_op(input logic [OP_W-1:0] op);
    alu_ctl_t c;
    c = '0;
    case (op)
      OP_AND: c = '{legal: 1'b1, op1: 1'b0, op2: 1'b0, sub: 1'b0, cin: 1'b0};
      OP_OR:  c = '{legal: 1'b1, op1: 1'b0, op2: 1'b1, sub: 1'b0, cin: 1'b0};
      OP_ADD: c = '{legal: 1'b1, op1: 1'b1, op2: 1'b0, sub: 1'b0, cin: 1'b0};
      OP_SUB: c = '{legal: 1'b1, op1: 1'b1, op2: 1'b0, sub: 1'b1, cin: 1'b1};
      OP_SLT: c = '{legal: 1'b1, op1: 1'b1, op2: 1'b1, sub: 1'b1, cin: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin arbiter; ptr names the favoured requester
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~ptr | ~req[1]);
    gnt[1] = req[1] & ( ptr | ~req[0]);
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_ctrl.sv
// ============================================================================
// Module  : alu_share_ctrl
// Brief   : Shares one external ripple ALU between two requesters (RR grant)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic [W-1:0]         alu_a,
  output logic [W-1:0]         alu_b,
  output logic [W-1:0]         alu_op1,
  output logic [W-1:0]         alu_op2,
  output logic [W-1:0]         alu_sub,
  output logic                 alu_cin,
  input  logic [W-1:0]         alu_out,
  input  logic                 alu_zero,
  input  logic                 alu_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_cout,
  output logic                 rsp_err
);

  state_t          r_state;
  state_t          w_next_state;
  logic            r_ptr;
  logic [OP_W-1:0] r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_id;
  logic [1:0]      w_gnt;
  logic            w_accept;
  alu_ctl_t        w_ctl;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_accept = (r_state == ST_IDLE) && (|req_valid);
  assign w_ctl    = decode_op(r_op);

  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_sub      = '0;
    alu_cin      = 1'b0;
    rsp_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_gnt;
        if (|req_valid) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        // Only latched operands reach the ALU so its inputs never glitch with requester activity.
        if (w_ctl.legal) begin
          alu_a   = r_a;
          alu_b   = r_b;
          alu_op1 = {W{w_ctl.op1}};
          alu_op2 = {W{w_ctl.op2}};
          alu_sub = {W{w_ctl.sub}};
          alu_cin = w_ctl.cin;
        end
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_cout <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_id <= w_gnt[1];
        if (w_gnt[1]) begin
          r_op <= req_op[OP_W +: OP_W];
          r_a  <= req_a[W +: W];
          r_b  <= req_b[W +: W];
        end else begin
          r_op <= req_op[0 +: OP_W];
          r_a  <= req_a[0 +: W];
          r_b  <= req_b[0 +: W];
        end
      end
      if (r_state == ST_EXEC) begin
        rsp_id <= r_id;
        if (w_ctl.legal) begin
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
          rsp_cout <= alu_cout;
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= '0;
          rsp_zero <= 1'b0;
          rsp_cout <= 1'b0;
          rsp_err  <= 1'b1;
        end
      end
      // Hand priority to the requester that was not just served.
      if ((r_state == ST_RESP) && rsp_ready) r_ptr <= ~rsp_id;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
// ============================================================================
// Module  : tb_alu_share_ctrl
// Brief   : Scoreboard bench for alu_share_ctrl with a behavioural ripple ALU
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [5:0]    req_op = '0;
  logic [2*W-1:0] req_a = '0;
  logic [2*W-1:0] req_b = '0;
  logic [W-1:0]  alu_a, alu_b, alu_op1, alu_op2, alu_sub;
  logic          alu_cin;
  logic [W-1:0]  alu_out;
  logic          alu_zero, alu_cout;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_id;
  logic [W-1:0]  rsp_data;
  logic          rsp_zero, rsp_cout, rsp_err;

  alu_share_ctrl #(.W(W), .NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sub(alu_sub), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural per-bit ripple ALU: mux (op1,op2) picks AND/OR/SUM/LESS.
  logic [W-1:0] w_bb, w_less;
  logic [W:0]   w_sum;
  assign w_bb     = alu_b ^ alu_sub;
  assign w_sum    = {1'b0, alu_a} + {1'b0, w_bb} + {{W{1'b0}}, alu_cin};
  assign w_less   = {{(W-1){1'b0}}, w_sum[W-1]};
  assign alu_out  = (~alu_op1 & ~alu_op2 & (alu_a & alu_b)) |
                    (~alu_op1 &  alu_op2 & (alu_a | alu_b)) |
                    ( alu_op1 & ~alu_op2 & w_sum[W-1:0])    |
                    ( alu_op1 &  alu_op2 & w_less);
  assign alu_zero = (alu_out == '0);
  assign alu_cout = w_sum[W];

  typedef struct packed {
    logic         id;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } txn_t;

  txn_t q[$];
  txn_t m_cur;
  int   checks = 0;
  int   errors = 0;
  int   resp_cnt = 0;
  logic [1:0] m_state = 2'd0;
  logic m_ptr = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {err, cout, zero, data}
  function automatic logic [W+2:0] model_rsp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s_add, s_sub;
    logic [W-1:0] d;
    logic         c;
    s_add = {1'b0, a} + {1'b0, b};
    s_sub = {1'b0, a} + {1'b0, ~b} + 1;
    case (op)
      3'd0: begin d = a & b;     c = s_add[W]; end
      3'd1: begin d = a | b;     c = s_add[W]; end
      3'd2: begin d = s_add[W-1:0]; c = s_add[W]; end
      3'd3: begin d = s_sub[W-1:0]; c = s_sub[W]; end
      3'd4: begin d = {{(W-1){1'b0}}, s_sub[W-1]}; c = s_sub[W]; end
      default: return {1'b1, 1'b0, 1'b0, {W{1'b0}}};
    endcase
    return {1'b0, c, (d == '0), d};
  endfunction

  // {legal, op1, op2, sub, cin}
  function automatic logic [4:0] model_ctl(input logic [2:0] op);
    case (op)
      3'd0: return 5'b10000;
      3'd1: return 5'b10100;
      3'd2: return 5'b11000;
      3'd3: return 5'b11011;
      3'd4: return 5'b11111;
      default: return 5'b00000;
    endcase
  endfunction

  // Reference controller model: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    logic [1:0]   g;
    logic [4:0]   ctl;
    logic [W+2:0] r;
    if (rst) begin
      m_state = 2'd0;
      m_ptr   = 1'b0;
      q.delete();
    end else begin
      ctl = (m_state == 2'd1) ? model_ctl(m_cur.op) : 5'b0;
      chk("alu_a",   alu_a,   ctl[4] ? m_cur.a : '0);
      chk("alu_b",   alu_b,   ctl[4] ? m_cur.b : '0);
      chk("alu_sel", {alu_op1, alu_op2, alu_sub, alu_cin},
          {{W{ctl[3]}}, {W{ctl[2]}}, {W{ctl[1]}}, ctl[0]});
      chk("rsp_valid", rsp_valid, m_state == 2'd2);
      g = 2'b00;
      if (m_state == 2'd0) g = (req_valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", req_ready, g);
      case (m_state)
        2'd0: if (g != 2'b00) begin
          m_cur.id = g[1];
          m_cur.op = req_op[g[1]*3 +: 3];
          m_cur.a  = req_a[g[1]*W +: W];
          m_cur.b  = req_b[g[1]*W +: W];
          q.push_back(m_cur);
          m_state = 2'd1;
        end
        2'd1: m_state = 2'd2;
        default: begin
          if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
            m_state = 2'd0;
          end else begin
            r = model_rsp(q[0].op, q[0].a, q[0].b);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, r[W-1:0]);
            chk("rsp_flags", {rsp_err, rsp_cout, rsp_zero}, r[W+2:W]);
            if (rsp_ready) begin
              m_ptr = ~q[0].id;
              void'(q.pop_front());
              resp_cnt++;
              m_state = 2'd0;
            end
          end
        end
      endcase
    end
  end

  task automatic send(input int k, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    req_op[k*3 +: 3] = op;
    req_a[k*W +: W]  = a;
    req_b[k*W +: W]  = b;
    req_valid[k]     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid[k]     = 1'b0;
    req_a[k*W +: W]  = 32'hDEADBEEF;
    req_b[k*W +: W]  = 32'h12345678;
    req_op[k*3 +: 3] = 3'b001;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && m_state == 2'd0) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int base;
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_op1", alu_op1, 0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_zero, rsp_cout, rsp_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(0, 3'b010, 32'd40, 32'd10);          // ADD
    wait_idle();
    send(1, 3'b011, 32'd10, 32'd10);          // SUB -> zero, cout
    wait_idle();

    base = resp_cnt;
    req_op = {3'b001, 3'b000};
    req_a  = {32'd60, 32'd60};
    req_b  = {32'd30, 32'd30};
    req_valid = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    chk("rr_count", resp_cnt - base, 4);

    rsp_ready = 1'b0;
    send(0, 3'b010, 32'd7, 32'd8);
    req_op[5:3] = 3'b001; req_a[2*W-1:W] = 32'd1; req_b[2*W-1:W] = 32'd2;
    req_valid = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();

    send(0, 3'b110, 32'd5, 32'd6);            // illegal
    wait_idle();
    send(1, 3'b100, 32'd5, 32'd9);            // SLT
    wait_idle();
    send(0, 3'b100, 32'hFFFFFFFF, 32'd1);     // SLT, -1 < 1
    wait_idle();

    // Async reset while the op sits in EXEC.
    send(1, 3'b010, 32'd3, 32'd4);
    #3 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_alu", {alu_op1, alu_a, alu_cin}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = resp_cnt;
    req_op = {3'b001, 3'b000};
    req_a  = {32'd60, 32'd60};
    req_b  = {32'd30, 32'd30};
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    wait_idle();
    chk("post_rst_count", resp_cnt - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
